// File: rtl/any1_wb_arbiter_pkg.sv
// Shared writeback-arbiter definitions: functional-unit codes, the sFuncUnit
// result record, and the requester count.
package any1_wb_arbiter_pkg;

  localparam logic [1:0] FU_EXEC = 2'd0;
  localparam logic [1:0] FU_MUL  = 2'd1;
  localparam logic [1:0] FU_DIV  = 2'd2;
  localparam logic [1:0] FU_MEM  = 2'd3;

  typedef struct packed {
    logic        cmt;
    logic [5:0]  rid;
    logic [5:0]  ele;
    logic [63:0] res;
    logic [7:0]  cause;
    logic [63:0] badAddr;
  } sFuncUnit;

  localparam int NFU      = 4;
  localparam int SFU_BITS = $bits(sFuncUnit);

endpackage

// File: rtl/any1_wb_fifo.sv
// Per-unit QDEPTH-entry sFuncUnit queue; push and pop may occur together.
module any1_wb_fifo
  import any1_wb_arbiter_pkg::*;
#(
  parameter int QDEPTH = 2,
  localparam int PW = $clog2(QDEPTH),
  localparam int CW = PW + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic          pop,
  input  sFuncUnit      din,
  output sFuncUnit      head,
  output logic [CW-1:0] count
);

  sFuncUnit      mem [QDEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage needs no reset: count gates every read of it.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= din;
  end

  assign head = mem[rd_ptr];

endmodule

// File: rtl/any1_wb_arbiter.sv
// Writeback arbiter: NFU result queues scheduled round-robin onto one registered
// ROB update port. Define WBARB_FIXED_PRI_EN for fixed priority (MEM highest).
module any1_wb_arbiter
  import any1_wb_arbiter_pkg::*;
#(
  parameter int NFU    = any1_wb_arbiter_pkg::NFU,
  parameter int QDEPTH = 2
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic [NFU-1:0]          fu_v_i,
  input  logic [NFU*SFU_BITS-1:0] fu_i,
  output logic [NFU-1:0]          fu_rdy_o,
  input  logic                    rob_stall_i,
  output logic                    wb_v_o,
  output sFuncUnit                wb_o,
  output logic [1:0]              wb_fu_o
);

  localparam int CW = $clog2(QDEPTH) + 1;
  localparam int RW = $clog2(NFU);

  sFuncUnit       head  [NFU];
  logic [CW-1:0]  count [NFU];
  logic [NFU-1:0] push;
  logic [NFU-1:0] pop;
  logic           found;
  logic [1:0]     g;

  for (genvar k = 0; k < NFU; k++) begin : g_unit
    // Ready comes from the registered count only, so a full queue stays
    // not-ready even in a cycle where it is popped.
    assign fu_rdy_o[k] = (count[k] != CW'(QDEPTH)) & ~rst_i;
    assign push[k]     = fu_v_i[k] & fu_rdy_o[k];
    assign pop[k]      = found & ~rob_stall_i & (g == 2'(k));

    any1_wb_fifo #(.QDEPTH(QDEPTH)) u_fifo (
      .clk   (clk_i),
      .rst   (rst_i),
      .push  (push[k]),
      .pop   (pop[k]),
      .din   (fu_i[k*SFU_BITS +: SFU_BITS]),
      .head  (head[k]),
      .count (count[k])
    );
  end

`ifdef WBARB_FIXED_PRI_EN
  always_comb begin
    found = 1'b0;
    g     = '0;
    // Ascending scan so the highest-numbered non-empty unit wins.
    for (int i = 0; i < NFU; i++) begin
      if (count[RW'(i)] != '0) begin
        found = 1'b1;
        g     = 2'(i);
      end
    end
  end
`else
  logic [RW-1:0] rr;
  logic [RW-1:0] idx;

  always_comb begin
    found = 1'b0;
    g     = '0;
    idx   = '0;
    // Descending offset scan: the last hit is the one closest to rr.
    for (int i = NFU - 1; i >= 0; i--) begin
      idx = rr + RW'(i);
      if (count[idx] != '0) begin
        found = 1'b1;
        g     = 2'(idx);
      end
    end
  end
`endif

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wb_v_o  <= 1'b0;
      wb_o    <= '0;
      wb_fu_o <= '0;
`ifndef WBARB_FIXED_PRI_EN
      rr      <= '0;
`endif
    end else if (!rob_stall_i) begin
      if (found) begin
        wb_v_o  <= 1'b1;
        wb_o    <= head[g];
        wb_fu_o <= g;
`ifndef WBARB_FIXED_PRI_EN
        rr      <= RW'(g + 2'd1);
`endif
      end else begin
        wb_v_o  <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_any1_wb_arbiter.sv
// Self-checking bench for any1_wb_arbiter: directed scenarios plus random
// traffic, all compared against a queue-based model of the arbitration rules.
module tb_any1_wb_arbiter;
  import any1_wb_arbiter_pkg::*;

  localparam int W  = SFU_BITS;
  localparam int QD = 2;

  logic             clk_i = 1'b0;
  logic             rst_i = 1'b0;
  logic [NFU-1:0]   fu_v_i = '0;
  logic [NFU*W-1:0] fu_i = '0;
  logic [NFU-1:0]   fu_rdy_o;
  logic             rob_stall_i = 1'b0;
  logic             wb_v_o;
  sFuncUnit         wb_o;
  logic [1:0]       wb_fu_o;

  any1_wb_arbiter #(.NFU(NFU), .QDEPTH(QD)) dut (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .fu_v_i      (fu_v_i),
    .fu_i        (fu_i),
    .fu_rdy_o    (fu_rdy_o),
    .rob_stall_i (rob_stall_i),
    .wb_v_o      (wb_v_o),
    .wb_o        (wb_o),
    .wb_fu_o     (wb_fu_o)
  );

  always #5 clk_i = ~clk_i;

  int n_chk  = 0;
  int n_fail = 0;
  int n_xfer = 0;

  sFuncUnit       mq [NFU][$];
  int             m_rr;
  logic           m_v;
  sFuncUnit       m_wb;
  logic [1:0]     m_fu;

  sFuncUnit       drv [NFU];
  logic [NFU-1:0] drv_v;
  logic           drv_stall;

  task automatic chk(input string tag, input logic [191:0] obs, input logic [191:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic sFuncUnit mk(input int rid, input logic [63:0] res);
    sFuncUnit r;
    r.cmt     = 1'($urandom_range(0, 1));
    r.rid     = 6'(rid);
    r.ele     = 6'($urandom_range(0, 63));
    r.res     = res;
    r.cause   = 8'($urandom_range(0, 255));
    r.badAddr = {$urandom, $urandom};
    return r;
  endfunction

  // Which unit the scheduler should pick given current model queues, or -1.
  function automatic int m_grant();
`ifdef WBARB_FIXED_PRI_EN
    for (int i = NFU - 1; i >= 0; i--)
      if (mq[i].size() > 0) return i;
`else
    for (int i = 0; i < NFU; i++)
      if (mq[(m_rr + i) % NFU].size() > 0) return (m_rr + i) % NFU;
`endif
    return -1;
  endfunction

  task automatic model_clear();
    for (int k = 0; k < NFU; k++) mq[k].delete();
    m_rr = 0;
    m_v  = 1'b0;
    m_wb = '0;
    m_fu = '0;
  endtask

  // One clock: apply drv_*, check ready, advance the model, check the outputs.
  task automatic cycle();
    logic [NFU-1:0] er;
    int gr;
    rob_stall_i = drv_stall;
    fu_v_i      = drv_v;
    for (int k = 0; k < NFU; k++) fu_i[k*W +: W] = drv[k];
    for (int k = 0; k < NFU; k++) er[k] = (mq[k].size() < QD);
    chk("rdy", 192'(fu_rdy_o), 192'(er));
    if (wb_v_o && !drv_stall) n_xfer++;
    if (!drv_stall) begin
      gr = m_grant();
      if (gr >= 0) begin
        m_wb = mq[gr].pop_front();
        m_fu = 2'(gr);
        m_v  = 1'b1;
        m_rr = (gr + 1) % NFU;
      end else begin
        m_v = 1'b0;
      end
    end
    for (int k = 0; k < NFU; k++)
      if (drv_v[k] && er[k]) mq[k].push_back(drv[k]);
    @(posedge clk_i);
    #1;
    chk("wb_v", 192'(wb_v_o), 192'(m_v));
    chk("wb_fu", 192'(wb_fu_o), 192'(m_fu));
    chk("wb", 192'(wb_o), 192'(m_wb));
  endtask

  task automatic idle(input int n);
    drv_v     = '0;
    drv_stall = 1'b0;
    repeat (n) cycle();
  endtask

  task automatic reset_dut();
    rst_i       = 1'b1;
    fu_v_i      = '0;
    rob_stall_i = 1'b0;
    drv_v       = '0;
    drv_stall   = 1'b0;
    #1;
    chk("rst_wbv", 192'(wb_v_o), 192'(0));
    chk("rst_rdy", 192'(fu_rdy_o), 192'(0));
    model_clear();
    repeat (2) @(posedge clk_i);
    #1;
    chk("rst_rdy_hold", 192'(fu_rdy_o), 192'(0));
    chk("rst_wb", 192'(wb_o), 192'(0));
    chk("rst_wbfu", 192'(wb_fu_o), 192'(0));
    rst_i = 1'b0;
    #1;
    chk("rdy_after_rst", 192'(fu_rdy_o), 192'(4'hF));
  endtask

  initial begin
    logic [1:0] exp4 [4];
    sFuncUnit   snap;
    logic [1:0] snap_fu;

    for (int k = 0; k < NFU; k++) drv[k] = '0;
    drv_v = '0;
    drv_stall = 1'b0;
    model_clear();
    #2;
    reset_dut();

    // Single record through FU_MUL.
    drv[1] = mk(5, 64'hDEAD);
    drv_v  = 4'b0010;
    cycle();
    chk("single_e1_v", 192'(wb_v_o), 192'(0));
    idle(1);
    chk("single_v", 192'(wb_v_o), 192'(1));
    chk("single_rid", 192'(wb_o.rid), 192'(5));
    chk("single_res", 192'(wb_o.res), 192'(64'hDEAD));
    chk("single_fu", 192'(wb_fu_o), 192'(1));
    idle(1);
    chk("single_e3_v", 192'(wb_v_o), 192'(0));

    // All four units at once.
    reset_dut();
`ifdef WBARB_FIXED_PRI_EN
    exp4 = '{2'd3, 2'd2, 2'd1, 2'd0};
`else
    exp4 = '{2'd0, 2'd1, 2'd2, 2'd3};
`endif
    for (int k = 0; k < NFU; k++) drv[k] = mk(10 + k, 64'(k));
    drv_v = 4'hF;
    cycle();
    drv_v = '0;
    for (int i = 0; i < 4; i++) begin
      cycle();
      chk("all4_v", 192'(wb_v_o), 192'(1));
      chk("all4_fu", 192'(wb_fu_o), 192'(exp4[i]));
    end
    drv[0] = mk(20, 64'h20);
    drv[1] = mk(21, 64'h21);
    drv_v  = 4'b0011;
    cycle();
    idle(1);
`ifdef WBARB_FIXED_PRI_EN
    chk("rr_wrap_fu", 192'(wb_fu_o), 192'(1));
`else
    chk("rr_wrap_fu", 192'(wb_fu_o), 192'(0));
`endif
    idle(3);

    // Backpressure on FU_EXEC.
    drv_stall = 1'b1;
    drv_v     = 4'b0001;
    drv[0] = mk(1, 64'd100); cycle();
    drv[0] = mk(2, 64'd101); cycle();
    chk("bp_rdy0", 192'(fu_rdy_o[0]), 192'(0));
    drv[0] = mk(3, 64'd102); cycle();
    chk("bp_frozen_v", 192'(wb_v_o), 192'(0));
    idle(1);
    chk("bp_first", 192'(wb_o.res), 192'(100));
    chk("bp_first_fu", 192'(wb_fu_o), 192'(0));
    idle(1);
    chk("bp_second", 192'(wb_o.res), 192'(101));
    idle(1);
    chk("bp_drained", 192'(wb_v_o), 192'(0));

    // Stall mid-stream.
    drv[1] = mk(7, 64'd200);
    drv[2] = mk(8, 64'd201);
    drv_v  = 4'b0110;
    cycle();
    idle(1);
    chk("sm_v", 192'(wb_v_o), 192'(1));
    snap    = m_wb;
    snap_fu = m_fu;
    n_xfer  = 0;
    drv_stall = 1'b1;
    drv_v     = '0;
    for (int i = 0; i < 3; i++) begin
      cycle();
      chk("sm_hold_wb", 192'(wb_o), 192'(snap));
      chk("sm_hold_fu", 192'(wb_fu_o), 192'(snap_fu));
      chk("sm_hold_v", 192'(wb_v_o), 192'(1));
    end
    idle(3);
    chk("sm_xfers", 192'(n_xfer), 192'(2));

    // Reset with two entries queued in FU_DIV and a valid writeback held.
    reset_dut();
    drv_v = 4'b0100;
    drv[2] = mk(30, 64'd300); cycle();
    drv[2] = mk(31, 64'd301); cycle();
    drv_stall = 1'b1;
    drv[2] = mk(32, 64'd302); cycle();
    chk("pre_rst_wbv", 192'(wb_v_o), 192'(1));
    chk("pre_rst_rdy2", 192'(fu_rdy_o[2]), 192'(0));
    #2;
    reset_dut();
    idle(3);
    chk("post_rst_v", 192'(wb_v_o), 192'(0));

`ifdef WBARB_FIXED_PRI_EN
    // EXEC and MEM each hold two entries.
    drv_stall = 1'b1;
    drv_v     = 4'b1001;
    drv[0] = mk(40, 64'd40); drv[3] = mk(41, 64'd41); cycle();
    drv[0] = mk(42, 64'd42); drv[3] = mk(43, 64'd43); cycle();
    exp4 = '{2'd3, 2'd3, 2'd0, 2'd0};
    drv_v = '0;
    drv_stall = 1'b0;
    for (int i = 0; i < 4; i++) begin
      cycle();
      chk("fixpri_fu", 192'(wb_fu_o), 192'(exp4[i]));
    end
    idle(1);
`endif

    // Random traffic.
    for (int i = 0; i < 400; i++) begin
      drv_v     = 4'($urandom_range(0, 15));
      drv_stall = ($urandom_range(0, 3) == 0);
      for (int k = 0; k < NFU; k++) drv[k] = mk($urandom_range(0, 63), {$urandom, $urandom});
      cycle();
    end
    idle(10);
    chk("final_idle_v", 192'(wb_v_o), 192'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
